// File: rtl/fb_scanout_scheduler_pkg.sv
// Shared constants and encodings for the framebuffer scan-out scheduler.
package fb_scanout_scheduler_pkg;

  localparam int FB_WIDTH    = 180;
  localparam int FB_HEIGHT   = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int PIXEL_WIDTH = 8;
  localparam int ADDR_WIDTH  = 15;
  localparam int H_BITS      = 11;
  localparam int V_BITS      = 10;
  localparam int H_LAST      = 719;

  typedef enum logic {
    GRANT_FETCH  = 1'b0,
    GRANT_WRITER = 1'b1
  } grant_t;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fb_scanout_scheduler_line_buffer_pingpong.sv
// Two-bank line buffer: one write port, one registered read port that
// outputs zero when the read is not enabled.
module line_buffer_pingpong
  import fb_scanout_scheduler_pkg::*;
#(
  parameter int DEPTH  = FB_WIDTH,
  parameter int DATA_W = PIXEL_WIDTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_bank_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o <= {DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_o <= mem_q[rd_bank_i][rd_addr_i];
    end else begin
      rd_data_o <= {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/fb_scanout_scheduler.sv
// Shares one framebuffer BSRAM between scan-out line fetches and a draw-engine
// writer, and produces the upscaled pixel stream for hdmi_tx.
module fb_scanout_scheduler #(
  parameter int FB_WIDTH    = fb_scanout_scheduler_pkg::FB_WIDTH,
  parameter int FB_HEIGHT   = fb_scanout_scheduler_pkg::FB_HEIGHT,
  parameter int SCALE_SHIFT = fb_scanout_scheduler_pkg::SCALE_SHIFT,
  parameter int PIXEL_WIDTH = fb_scanout_scheduler_pkg::PIXEL_WIDTH,
  parameter int ADDR_WIDTH  = fb_scanout_scheduler_pkg::ADDR_WIDTH,
  parameter int H_BITS      = fb_scanout_scheduler_pkg::H_BITS,
  parameter int V_BITS      = fb_scanout_scheduler_pkg::V_BITS,
  parameter int H_LAST      = fb_scanout_scheduler_pkg::H_LAST
) (
  input  logic                     pixelClock,
  input  logic                     nReset,
  input  logic signed [H_BITS-1:0] hPosCounter,
  input  logic signed [V_BITS-1:0] vPosCounter,
  input  logic                     wrValid,
  input  logic [ADDR_WIDTH-1:0]    wrAddr,
  input  logic [PIXEL_WIDTH-1:0]   wrData,
  output logic                     wrReady,
  output logic [ADDR_WIDTH-1:0]    fbAddr,
  output logic                     fbWe,
  output logic                     fbRe,
  output logic [PIXEL_WIDTH-1:0]   fbWData,
  input  logic [PIXEL_WIDTH-1:0]   fbRData,
  output logic [PIXEL_WIDTH-1:0]   pixelOut,
  output logic                     underrun
);
  import fb_scanout_scheduler_pkg::*;

  localparam int                    COL_W    = $clog2(FB_WIDTH);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(FB_WIDTH - 1);
  localparam logic [V_BITS:0]       V_ACTIVE = (V_BITS+1)'(FB_HEIGHT << SCALE_SHIFT);
  localparam logic [V_BITS-1:0]     ROW_LAST = V_BITS'(FB_HEIGHT - 1);
  localparam logic [H_BITS-1:0]     H_LAST_U = H_BITS'(H_LAST);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

  fetch_state_t            state_q, state_d;
  grant_t                  last_grant_q, last_grant_d;
  logic [COL_W-1:0]        col_q, col_d, rd_col_q;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic                    active_bank_q, active_bank_d;
  logic                    underrun_q, underrun_d;
  logic                    rd_pending_q, lb_bank_q;
  logic [H_BITS-1:0]       h_u_s;
  logic [V_BITS-1:0]       v_u_s;
  logic [V_BITS:0]         v_next_s;
  logic                    v_first_s, trig_s, swap_s, pix_active_s;
  logic                    fetch_req_s, busy_s, wr_req_s, grant_fetch_s, grant_wr_s;

  assign h_u_s     = hPosCounter;
  assign v_u_s     = vPosCounter;
  assign v_next_s  = {1'b0, v_u_s} + {{V_BITS{1'b0}}, 1'b1};
  assign v_first_s = (v_u_s == {V_BITS{1'b1}});

  // T starts a row fetch; the swap fires at the end of the line before a new fb row.
  assign trig_s = (h_u_s == {H_BITS{1'b0}}) &&
                  (v_first_s || (!v_u_s[V_BITS-1] &&
                                 (v_u_s[SCALE_SHIFT-1:0] == {SCALE_SHIFT{1'b0}}) &&
                                 ((v_u_s >> SCALE_SHIFT) < ROW_LAST)));
  assign swap_s = (h_u_s == H_LAST_U) &&
                  (v_first_s || (!v_u_s[V_BITS-1] &&
                                 (v_next_s[SCALE_SHIFT-1:0] == {SCALE_SHIFT{1'b0}}) &&
                                 (v_next_s < V_ACTIVE)));
  assign pix_active_s = !h_u_s[H_BITS-1] && (h_u_s <= H_LAST_U) &&
                        !v_u_s[V_BITS-1] && ({1'b0, v_u_s} < V_ACTIVE);

  // Fetch FSM state register
  always_ff @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state: a swap aborts, a trigger restarts
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE:  state_d = trig_s ? FETCH_RUN : FETCH_IDLE;
      FETCH_RUN: begin
        if (swap_s) begin
          state_d = FETCH_IDLE;
        end else if (trig_s) begin
          state_d = FETCH_RUN;
        end else if (grant_fetch_s && (col_q == COL_LAST)) begin
          state_d = FETCH_DRAIN;
        end else begin
          state_d = FETCH_RUN;
        end
      end
      FETCH_DRAIN: begin
        if (swap_s) begin
          state_d = FETCH_IDLE;
        end else if (trig_s) begin
          state_d = FETCH_RUN;
        end else begin
          state_d = FETCH_IDLE;
        end
      end
      default:     state_d = FETCH_IDLE;
    endcase
  end

  // Fetch FSM outputs
  always_comb begin
    fetch_req_s = (state_q == FETCH_RUN) && !swap_s && !trig_s;
    busy_s      = (state_q != FETCH_IDLE);
  end

  // Round-robin arbiter and BSRAM port mux; reset masks the writer grant at once
  always_comb begin
    wr_req_s      = wrValid && nReset;
    grant_fetch_s = fetch_req_s && (!wr_req_s || (last_grant_q == GRANT_WRITER));
    grant_wr_s    = wr_req_s && (!fetch_req_s || (last_grant_q == GRANT_FETCH));
    wrReady       = grant_wr_s;
    fbWe          = grant_wr_s;
    fbRe          = grant_fetch_s;
    if (grant_wr_s) begin
      fbAddr  = wrAddr;
      fbWData = wrData;
    end else if (grant_fetch_s) begin
      fbAddr  = row_base_q + ADDR_WIDTH'(col_q);
      fbWData = {PIXEL_WIDTH{1'b0}};
    end else begin
      fbAddr  = {ADDR_WIDTH{1'b0}};
      fbWData = {PIXEL_WIDTH{1'b0}};
    end
  end

  // Datapath next-state
  always_comb begin
    col_d         = col_q;
    row_base_d    = row_base_q;
    last_grant_d  = last_grant_q;
    active_bank_d = swap_s ? ~active_bank_q : active_bank_q;
    underrun_d    = underrun_q | ((swap_s || trig_s) && busy_s);
    if (trig_s) begin
      col_d = {COL_W{1'b0}};
    end else if (grant_fetch_s) begin
      col_d = col_q + {{(COL_W-1){1'b0}}, 1'b1};
    end else begin
      col_d = col_q;
    end
    if (trig_s && v_first_s) begin
      row_base_d = {ADDR_WIDTH{1'b0}};
    end else if (trig_s) begin
      row_base_d = row_base_q + ROW_STEP;
    end else begin
      row_base_d = row_base_q;
    end
    if (grant_fetch_s) begin
      last_grant_d = GRANT_FETCH;
    end else if (grant_wr_s) begin
      last_grant_d = GRANT_WRITER;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Datapath registers; read data lands one cycle after its grant
  always_ff @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      col_q         <= {COL_W{1'b0}};
      row_base_q    <= {ADDR_WIDTH{1'b0}};
      active_bank_q <= 1'b0;
      last_grant_q  <= GRANT_WRITER;
      underrun_q    <= 1'b0;
      rd_pending_q  <= 1'b0;
      rd_col_q      <= {COL_W{1'b0}};
      lb_bank_q     <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_base_q    <= row_base_d;
      active_bank_q <= active_bank_d;
      last_grant_q  <= last_grant_d;
      underrun_q    <= underrun_d;
      rd_pending_q  <= grant_fetch_s;
      rd_col_q      <= col_q;
      lb_bank_q     <= ~active_bank_q;
    end
  end

  assign underrun = underrun_q;

  line_buffer_pingpong #(
    .DEPTH  (FB_WIDTH),
    .DATA_W (PIXEL_WIDTH),
    .AW     (COL_W)
  ) u_line_buffer (
    .clk_i     (pixelClock),
    .rst_n_i   (nReset),
    .wr_en_i   (rd_pending_q),
    .wr_bank_i (lb_bank_q),
    .wr_addr_i (rd_col_q),
    .wr_data_i (fbRData),
    .rd_en_i   (pix_active_s),
    .rd_bank_i (active_bank_q),
    .rd_addr_i (h_u_s[COL_W+SCALE_SHIFT-1:SCALE_SHIFT]),
    .rd_data_o (pixelOut)
  );

endmodule

// File: doc/fb_scanout_scheduler.md
Name: fb_scanout_scheduler

Overview:
Shares one single-port framebuffer BSRAM between two users: video scan-out and a draw-engine writer. Scan-out line fetches go into an internal ping-pong line buffer, and the draw-engine writer uses a valid/ready port. The block sits between the framebuffer and hdmi_tx. It follows hdmi_tx's signed hPosCounter/vPosCounter and produces upscaled pixel data for the active area. Round-robin arbitration bounds the time each line fetch can take.

Parameters:
FB_WIDTH, 180, framebuffer pixels per row
FB_HEIGHT, 120, framebuffer rows
SCALE_SHIFT, 2, log2 of the upscale factor (each fb pixel is 4x4 display pixels)
PIXEL_WIDTH, 8, bits per stored pixel (RGB332)
ADDR_WIDTH, 15, framebuffer address width
H_BITS, 11, hPosCounter width (signed)
V_BITS, 10, vPosCounter width (signed)
H_LAST, 719, last active hPos value

Ports:
pixelClock  in  1  sole clock
nReset  in  1  asynchronous, active-low reset
hPosCounter  in  H_BITS signed  horizontal position from the timing generator
vPosCounter  in  V_BITS signed  vertical position from the timing generator
wrValid  in  1  writer request
wrAddr  in  ADDR_WIDTH  writer address
wrData  in  PIXEL_WIDTH  writer data
wrReady  out  1  writer granted this cycle (combinational)
fbAddr  out  ADDR_WIDTH  BSRAM address
fbWe  out  1  BSRAM write enable
fbRe  out  1  BSRAM read enable
fbWData  out  PIXEL_WIDTH  BSRAM write data
fbRData  in  PIXEL_WIDTH  BSRAM read data, valid 1 cycle after fbRe
pixelOut  out  PIXEL_WIDTH  scaled pixel, registered
underrun  out  1  sticky: a line fetch was incomplete at a bank swap

Behaviour:
- Reset: fetch FSM IDLE, activeBank=0, rowBase=0, lastGrant=writer, pixelOut=0, underrun=0.
- Reset clears fbWe/fbRe/wrReady immediately, asynchronously, mid-operation included. No further reads are issued until the next trigger.
- Trigger event T (cycle with hPos==0):
  - vPos==-1: fetch row 0; rowBase<=0.
  - Or vPos>=0, vPos[SCALE_SHIFT-1:0]==0 and row=vPos>>SCALE_SHIFT < FB_HEIGHT-1: fetch row+1; rowBase<=rowBase+FB_WIDTH.
  - There is no multiplier.
- Fetch target: the fetch always writes bank ~activeBank.
- Fetch FSM states: IDLE -> FETCH on T.
  - FETCH: request a read of rowBase+col, col=0..FB_WIDTH-1. col increments only on grant.
  - After the last grant -> DRAIN. DRAIN: 1 cycle to capture the final fbRData -> IDLE.
  - fbRData from the grant at col c is written to linebuf[~activeBank][c] on the next cycle.
- Arbitration (per cycle, combinational):
  - Only one requester: it is granted.
  - Both requesting: the one not in lastGrant wins; lastGrant updates on every grant.
  - Worst-case fetch time is 2*FB_WIDTH cycles.
  - wrReady = writer granted. The writer holds wrValid/wrAddr/wrData stable until wrReady.
  - Write grant: fbWe=1, fbAddr=wrAddr. Fetch grant: fbRe=1, fbAddr=rowBase+col. Idle: all 0.
- Bank swap, at the cycle hPos==H_LAST, when the next line starts a row:
  - Applies when vPos==-1, or (vPos+1)[SCALE_SHIFT-1:0]==0 with vPos+1 < FB_HEIGHT<<SCALE_SHIFT.
  - activeBank toggles.
  - If the FSM is not IDLE: underrun<=1, the FSM aborts to IDLE, and the swap still happens.
- T while the FSM is busy: underrun<=1, restart at col 0.
- Pixel path, latency 1 cycle from the hPos/vPos presented:
  - In the active area (0<=hPos<=H_LAST, 0<=vPos<FB_HEIGHT<<SCALE_SHIFT): pixelOut<=linebuf[activeBank][hPos>>SCALE_SHIFT].
  - Otherwise pixelOut<=0.
  - The integrator aligns this latency with hdmi_tx.
- underrun clears only on reset.

Decomposition:
- Shared package: SCALE_SHIFT, PIXEL_WIDTH, FB_WIDTH, FB_HEIGHT, and the grant encoding (GRANT_FETCH, GRANT_WRITER).
- Sub-module line_buffer_pingpong:
  - 2 banks x FB_WIDTH x PIXEL_WIDTH, one write port and one registered read port.
  - Bank select inputs for each port.
- The FSM, arbiter and swap logic stay in the top module.

Test Plan:
1. Reset, no writer, stimulus: line vPos=-1.
   Required: fbRe on the 180 cycles after hPos==0 with fbAddr 0..179. No underrun. At vPos=0, hPos 0..3, the cycle after, pixelOut=mem[0]; hPos 4 gives mem[1].
2. wrValid held high through a fetch.
   Required: grants alternate, first to fetch. wrReady every other cycle. The fetch ends within 360 cycles. Writes land at wrAddr.
3. Row progression over vPos 0..7.
   Required: fetch at vPos 0 reads addresses 180..359. Swap at hPos 719 of vPos 3. vPos 4 displays mem[180+(hPos>>2)].
4. Override FB_WIDTH=400, writer always valid.
   Required: fetch is incomplete at hPos 719 of vPos -1, underrun=1 and stays 1. The FSM is IDLE on the next cycle.
5. nReset low at fetch col 50.
   Required: fbRe/fbWe/wrReady are 0 immediately and pixelOut=0. After release, the next T restarts at col 0.
6. Last row.
   Required: no fetch is triggered at vPos 476. No swap at the end of vPos 479. pixelOut=0 in blanking. vPos=-1 of the next frame refetches addresses 0..179.
